// File: rtl/alu_pkg.sv
// Shared ALU constants: operation encoding and the default adder geometry.
package alu_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam int ALU_WIDTH  = 16;
  localparam int ALU_BLOCK  = 4;
  localparam int ALU_STAGES = 2;

endpackage

// File: rtl/alu_cla_group.sv
// BLOCK-bit carry-lookahead group: bit sums for a given carry-in plus the
// group generate/propagate pair and the carry into the group's MSB.
module alu_cla_group
  import alu_pkg::*;
#(
  parameter int BLOCK = ALU_BLOCK
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] s_o,
  output logic             g_o,
  output logic             p_o,
  output logic             cmsb_o
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i | b_i;
    c    = '0;
    c[0] = cin_i;
    for (int i = 1; i < BLOCK; i++) begin
      c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    // Group terms depend only on a/b, so the parent lookahead has no path through cin.
    g_o = 1'b0;
    p_o = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      g_o = g[i] | (p[i] & g_o);
      p_o = p_o & p[i];
    end
    s_o    = a_i ^ b_i ^ c;
    cmsb_o = c[BLOCK-1];
  end

endmodule

// File: rtl/alu_pipe_cla_addsub.sv
// Pipelined CLA adder/subtractor: stage k resolves bit slice k from the carry
// registered by stage k-1, carrying the still-pending upper operand bits along.
module alu_pipe_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int BLOCK  = ALU_BLOCK,
  parameter int STAGES = ALU_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NG    = SLICE / BLOCK;

  if (WIDTH % (STAGES * BLOCK) != 0) begin : g_bad_geometry
    $error("alu_pipe_cla_addsub: WIDTH must be a multiple of STAGES*BLOCK");
  end

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign is_sub  = (in_sub == ALU_OP_SUB);
  assign b_eff   = is_sub ? ~in_b : in_b;
  assign cin_eff = is_sub ? 1'b1 : in_cin;

  // Handshake: a stage is ready when empty or when the stage after it is ready
  // (out_ready for the last stage); it loads new contents exactly when ready,
  // and takes data only when its upstream holds a valid op.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * SLICE;
    localparam int REM  = WIDTH - DONE;

    logic             valid_q;
    logic             carry_q;
    logic [DONE-1:0]  sum_q;
    logic [DONE-1:0]  sum_d;
    logic             rdy;
    logic             vin;
    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] ss;
    logic             scin;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_cmsb;
    logic [NG:0]      grp_c;

    if (k == 0) begin : g_first
      assign vin   = in_valid;
      assign sa    = in_a[SLICE-1:0];
      assign sb    = b_eff[SLICE-1:0];
      assign scin  = cin_eff;
      assign sum_d = ss;
    end else begin : g_next
      assign vin   = g_stage[k-1].valid_q;
      assign sa    = g_stage[k-1].g_rem.a_q[SLICE-1:0];
      assign sb    = g_stage[k-1].g_rem.b_q[SLICE-1:0];
      assign scin  = g_stage[k-1].carry_q;
      assign sum_d = {ss, g_stage[k-1].sum_q};
    end

    if (k == STAGES - 1) begin : g_rdy_last
      assign rdy = !valid_q | out_ready;
    end else begin : g_rdy_mid
      assign rdy = !valid_q | g_stage[k+1].rdy;
    end

    for (genvar j = 0; j < NG; j++) begin : g_grp
      alu_cla_group #(.BLOCK(BLOCK)) u_grp (
        .a_i    (sa[j*BLOCK +: BLOCK]),
        .b_i    (sb[j*BLOCK +: BLOCK]),
        .cin_i  (grp_c[j]),
        .s_o    (ss[j*BLOCK +: BLOCK]),
        .g_o    (grp_g[j]),
        .p_o    (grp_p[j]),
        .cmsb_o (grp_cmsb[j])
      );
    end

    always_comb begin
      grp_c    = '0;
      grp_c[0] = scin;
      for (int j = 0; j < NG; j++) begin
        grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        if (rdy) valid_q <= vin;
        if (rdy & vin) begin
          carry_q <= grp_c[NG];
          sum_q   <= sum_d;
        end
      end
    end

    // Operand bits above this slice travel with the op until their stage.
    if (REM > 0) begin : g_rem
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;

      if (k == 0) begin : g_src_in
        assign a_d = in_a[WIDTH-1:SLICE];
        assign b_d = b_eff[WIDTH-1:SLICE];
      end else begin : g_src_prev
        assign a_d = g_stage[k-1].g_rem.a_q[REM+SLICE-1:SLICE];
        assign b_d = g_stage[k-1].g_rem.b_q[REM+SLICE-1:SLICE];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy & vin) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_out
      logic ovf_q;
      logic zero_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (rdy & vin) begin
          ovf_q  <= grp_cmsb[NG-1] ^ grp_c[NG];
          zero_q <= (sum_d == '0);
        end
      end
    end
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[STAGES-1].valid_q;
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_cout  = g_stage[STAGES-1].carry_q;
  assign out_ovf   = g_stage[STAGES-1].g_out.ovf_q;
  assign out_zero  = g_stage[STAGES-1].g_out.zero_q;

endmodule
